// File: rtl/comparador_pkg.sv
// Shared encodings for the serial left-to-right comparator: cell state codes and FSM states.
package comparador_pkg;

    localparam logic [1:0] EST_A = 2'b01;  // equal so far
    localparam logic [1:0] EST_B = 2'b10;  // A > B, absorbing
    localparam logic [1:0] EST_C = 2'b11;  // A < B, absorbing

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } fsm_t;

endpackage

// File: rtl/comparador_serial_izq_der_celda.sv
// Typical cell of the left-to-right iterative comparator: present state (p,q) plus bit pair -> next state (P,Q).
module celdaTipicaIzqDer
    import comparador_pkg::*;
(
    input  logic p,
    input  logic q,
    input  logic Ai,
    input  logic Bi,
    output logic P,
    output logic Q
);

    always_comb begin
        {P, Q} = EST_A;
        case ({p, q})
            EST_B:   {P, Q} = EST_B;
            EST_C:   {P, Q} = EST_C;
            // EST_A and the never-written 00 code both behave as "equal so far"
            default: begin
                case ({Ai, Bi})
                    2'b10:   {P, Q} = EST_B;
                    2'b01:   {P, Q} = EST_C;
                    default: {P, Q} = EST_A;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/comparador_serial_izq_der.sv
// Serial comparator: one celdaTipicaIzqDer cell iterated over N clocks, MSB first.
// Optional macro EARLY_EXIT_EN ends the scan as soon as the cell reaches an absorbing state.
module comparador_serial_izq_der
    import comparador_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic         gt,
    output logic         lt,
    output logic         eq
);

    localparam int CW = $clog2(N + 1);

    fsm_t          state, state_nxt;
    logic [N-1:0]  sh_a, sh_b;
    logic [CW-1:0] cnt;
    logic [1:0]    estado, prox_estado;

    celdaTipicaIzqDer u_celda (
        .p  (estado[1]),
        .q  (estado[0]),
        .Ai (sh_a[N-1]),
        .Bi (sh_b[N-1]),
        .P  (prox_estado[1]),
        .Q  (prox_estado[0])
    );

    // Handshake: start is taken only while busy=0 (IDLE); busy stays high through the
    // DONE cycle, done pulses for exactly one cycle, and gt/lt/eq stay valid until the next accepted start.
    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (cnt == CW'(1)) state_nxt = S_DONE;
`ifdef EARLY_EXIT_EN
                if (prox_estado != EST_A) state_nxt = S_DONE;
`else
`endif
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            sh_a   <= '0;
            sh_b   <= '0;
            cnt    <= '0;
            estado <= EST_A;
            gt     <= 1'b0;
            lt     <= 1'b0;
            eq     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sh_a   <= A;
                        sh_b   <= B;
                        cnt    <= CW'(N);
                        estado <= EST_A;
                        gt     <= 1'b0;
                        lt     <= 1'b0;
                        eq     <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    estado <= prox_estado;
                    sh_a   <= sh_a << 1;
                    sh_b   <= sh_b << 1;
                    cnt    <= cnt - CW'(1);
                    // Latch the verdict on the DONE entry edge so it is valid alongside done
                    if (state_nxt == S_DONE) begin
                        gt <= (prox_estado == EST_B);
                        lt <= (prox_estado == EST_C);
                        eq <= (prox_estado == EST_A);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_comparador_serial_izq_der.sv
// Directed bench for comparador_serial_izq_der with N=8, N=4 and N=1 instances.
module tb_comparador_serial_izq_der;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start8 = 1'b0, busy8, done8, gt8, lt8, eq8;
    logic [7:0] a8 = '0, b8 = '0;
    logic       start4 = 1'b0, busy4, done4, gt4, lt4, eq4;
    logic [3:0] a4 = '0, b4 = '0;
    logic       start1 = 1'b0, busy1, done1, gt1, lt1, eq1;
    logic [0:0] a1 = '0, b1 = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    comparador_serial_izq_der #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .gt(gt8), .lt(lt8), .eq(eq8)
    );
    comparador_serial_izq_der #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4),
        .busy(busy4), .done(done4), .gt(gt4), .lt(lt4), .eq(eq4)
    );
    comparador_serial_izq_der #(.N(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1),
        .busy(busy1), .done(done1), .gt(gt1), .lt(lt1), .eq(eq1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if ({busy8, done8, gt8, lt8, eq8} !== 5'b0) begin
            bad++;
            $display("FAIL reset8 got=%b exp=00000", {busy8, done8, gt8, lt8, eq8});
        end
        total++;
        if ({busy4, done4, gt4, lt4, eq4, busy1, done1, gt1, lt1, eq1} !== 10'b0) begin
            bad++;
            $display("FAIL reset4_1 got=%b exp=0", {busy4, done4, gt4, lt4, eq4, busy1, done1, gt1, lt1, eq1});
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({busy8, done8, gt8, lt8, eq8} !== 5'b0) begin
                bad++;
                $display("FAIL idle_hold cyc=%0d got=%b exp=00000", i, {busy8, done8, gt8, lt8, eq8});
            end
        end
    endtask

    // One full N=8 transaction: expected result {gt,lt,eq} and latency in cycles from the accept edge.
    task automatic run8(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] exp_res, input int exp_lat);
        int n;
        start8 = 1'b1; a8 = a; b8 = b;
        tick();
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        total++;
        if ({busy8, gt8, lt8, eq8} !== 4'b1000) begin
            bad++;
            $display("FAIL %s busy_clear got=%b exp=1000", name, {busy8, gt8, lt8, eq8});
        end
        n = 0;
        while (!done8 && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (done8 !== 1'b1) begin
            bad++;
            $display("FAIL %s timeout got=no_done exp=done", name);
        end else begin
            total++;
            if (n + 1 != exp_lat) begin
                bad++;
                $display("FAIL %s latency got=%0d exp=%0d", name, n + 1, exp_lat);
            end
            total++;
            if ({gt8, lt8, eq8} !== exp_res) begin
                bad++;
                $display("FAIL %s result got=%b exp=%b", name, {gt8, lt8, eq8}, exp_res);
            end
        end
        tick();
        total++;
        if ({busy8, done8, gt8, lt8, eq8} !== {2'b00, exp_res}) begin
            bad++;
            $display("FAIL %s hold got=%b exp=%b", name, {busy8, done8, gt8, lt8, eq8}, {2'b00, exp_res});
        end
    endtask

    task automatic test_directed();
`ifdef EARLY_EXIT_EN
        run8("eq_5a",    8'h5A, 8'h5A, 3'b001, 9);
        run8("gt_80_7f", 8'h80, 8'h7F, 3'b100, 2);
        run8("lt_01_02", 8'h01, 8'h02, 3'b010, 8);
        run8("gt_80_00", 8'h80, 8'h00, 3'b100, 2);
        run8("gt_ff_fe", 8'hFF, 8'hFE, 3'b100, 9);
        run8("lt_00_ff", 8'h00, 8'hFF, 3'b010, 2);
`else
        run8("eq_5a",    8'h5A, 8'h5A, 3'b001, 9);
        run8("gt_80_7f", 8'h80, 8'h7F, 3'b100, 9);
        run8("lt_01_02", 8'h01, 8'h02, 3'b010, 9);
        run8("gt_80_00", 8'h80, 8'h00, 3'b100, 9);
        run8("gt_ff_fe", 8'hFF, 8'hFE, 3'b100, 9);
        run8("lt_00_ff", 8'h00, 8'hFF, 3'b010, 9);
`endif
    endtask

    task automatic test_start_while_busy();
        int n;
        start8 = 1'b1; a8 = 8'h3C; b8 = 8'h3D;
        tick();                       // accept edge k
        start8 = 1'b0;
        tick();                       // k+1
        tick();                       // k+2
        start8 = 1'b1; a8 = 8'h00; b8 = 8'h00;
        tick();                       // k+3, must be ignored
        start8 = 1'b0;
        n = 3;
        while (!done8 && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (done8 !== 1'b1 || n + 1 != 9) begin
            bad++;
            $display("FAIL busy_start latency got=%0d exp=9", n + 1);
        end
        total++;
        if ({gt8, lt8, eq8} !== 3'b010) begin
            bad++;
            $display("FAIL busy_start result got=%b exp=010", {gt8, lt8, eq8});
        end
    endtask

    task automatic test_back_to_back();
        int n;
        start8 = 1'b1; a8 = 8'h5A; b8 = 8'h5A;
        tick();
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 40) begin
            tick();
            n++;
        end
        // hold start through the done cycle: it must be ignored there
        start8 = 1'b1; a8 = 8'h80; b8 = 8'h7F;
        tick();
        total++;
        if ({busy8, done8, gt8, lt8, eq8} !== 5'b00001) begin
            bad++;
            $display("FAIL start_on_done got=%b exp=00001", {busy8, done8, gt8, lt8, eq8});
        end
        tick();
        start8 = 1'b0;
        total++;
        if ({busy8, gt8, lt8, eq8} !== 4'b1000) begin
            bad++;
            $display("FAIL restart got=%b exp=1000", {busy8, gt8, lt8, eq8});
        end
        n = 0;
        while (!done8 && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (done8 !== 1'b1 || {gt8, lt8, eq8} !== 3'b100) begin
            bad++;
            $display("FAIL restart_result got=%b exp=1100", {done8, gt8, lt8, eq8});
        end
        tick();
    endtask

    task automatic test_abort();
        int seen;
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
        tick();                       // k
        start8 = 1'b0;
        tick();
        tick();
        tick();                       // k+3
        rst = 1'b1;
        tick();                       // k+4
        total++;
        if ({busy8, done8, gt8, lt8, eq8} !== 5'b0) begin
            bad++;
            $display("FAIL abort got=%b exp=00000", {busy8, done8, gt8, lt8, eq8});
        end
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if ({busy8, done8, gt8, lt8, eq8} !== 5'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL abort_quiet got=%0d exp=0 nonzero cycles", seen);
        end
    endtask

    task automatic test_n1();
        int n;
        logic [2:0] exp_res;
        for (int v = 0; v < 4; v++) begin
            exp_res = (v == 2) ? 3'b100 : (v == 1) ? 3'b010 : 3'b001;
            start1 = 1'b1; a1 = 1'(v >> 1); b1 = 1'(v);
            tick();
            start1 = 1'b0;
            n = 0;
            while (!done1 && n < 10) begin
                tick();
                n++;
            end
            total++;
            if (done1 !== 1'b1 || n + 1 != 2 || {gt1, lt1, eq1} !== exp_res) begin
                bad++;
                $display("FAIL n1 v=%0d got=lat%0d res%b exp=lat2 res%b", v, n + 1, {gt1, lt1, eq1}, exp_res);
            end
            tick();
        end
    endtask

    task automatic test_sweep4();
        int n;
        logic [2:0] exp_res;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                exp_res = {a > b, a < b, a == b};
                start4 = 1'b1; a4 = 4'(a); b4 = 4'(b);
                tick();
                start4 = 1'b0;
                n = 0;
                while (!done4 && n < 10) begin
                    tick();
                    n++;
                end
                total++;
                if (done4 !== 1'b1 || {gt4, lt4, eq4} !== exp_res) begin
                    bad++;
                    $display("FAIL sweep a=%0d b=%0d got=%b exp=%b", a, b, {done4, gt4, lt4, eq4}, {1'b1, exp_res});
                end
                total++;
                if ($countones({gt4, lt4, eq4}) != 1) begin
                    bad++;
                    $display("FAIL onehot a=%0d b=%0d got=%b exp=one bit", a, b, {gt4, lt4, eq4});
                end
                tick();
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_while_busy();
        tick();
        test_back_to_back();
        test_abort();
        test_n1();
        test_sweep4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
